cache_access_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one direct-mapped cache lookup/update block among `NUM_CORES` requesting cores. It accepts one core request at a time, splits the address, restarts and times the cache lookup, and on a miss fetches the line from memory and commands the cache update. It then returns a hit/miss response to the winning core. It sits between the core request ports and the cache block, and also owns the memory-fill handshake.

---
 rtl/cache_access_arbiter.sv | 172 +++++++++++++++++
 tb/tb_cache_access_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_access_arbiter.sv
// Round-robin arbiter/sequencer sharing one direct-mapped cache lookup/update block among NUM_CORES cores.
// Latency: grant 1 cycle after req seen in IDLE; hit response at 2+LOOKUP_LAT; miss adds memory wait + fill + 1.
// Backpressure: one request in flight; requests are only sampled in IDLE, memory/cache handshakes stall the FSM.
module cache_access_arbiter #(
  parameter int NUM_CORES       = 4,
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int CACHE_SIZE_BYTE = 32768,
  parameter int LOOKUP_LAT      = 5,
  localparam int OFF_W  = $clog2(BLOCK_SIZE_BYTE),
  localparam int IDX_W  = $clog2(CACHE_SIZE_BYTE / BLOCK_SIZE_BYTE),
  localparam int TAG_W  = 32 - IDX_W - OFF_W,
  localparam int LINE_W = 8 * BLOCK_SIZE_BYTE
) (
  input  logic                    clk2,
  input  logic                    reset,
  input  logic [NUM_CORES-1:0]    req,
  input  logic [32*NUM_CORES-1:0] req_addr,
  output logic [NUM_CORES-1:0]    grant,
  output logic                    resp_valid,
  output logic [2:0]              resp_core,
  output logic                    resp_hit,
  output logic                    c_reset,
  output logic                    c_control,
  output logic [TAG_W-1:0]        c_tag,
  output logic [IDX_W-1:0]        c_index,
  output logic [OFF_W-1:0]        c_offset,
  output logic [LINE_W-1:0]       c_block,
  input  logic                    c_found,
  input  logic                    c_updated,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic                    mem_ready,
  input  logic [LINE_W-1:0]       mem_block,
  output logic [15:0]             hit_count,
  output logic [15:0]             miss_count
);

  localparam int CNT_W = $clog2(LOOKUP_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LOOKUP,
    S_FETCH,
    S_FILL,
    S_RESP
  } state_t;

  state_t               state;
  logic [2:0]           last_winner;
  logic [2:0]           win_q;
  logic [CNT_W-1:0]     lat_cnt;
  logic [15:0]          hit_cnt;
  logic [15:0]          miss_cnt;

  logic                 win_any;
  logic [2:0]           win_idx;
  logic [NUM_CORES-1:0] win_oh;
  logic [31:0]          win_addr;

  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;

  // Round-robin pick: scan from last_winner+1 with wrap; the nearest requester overrides farther ones.
  always_comb begin
    win_any  = 1'b0;
    win_idx  = '0;
    win_oh   = '0;
    win_addr = '0;
    for (int k = NUM_CORES; k >= 1; k--) begin
      int cand;
      cand = (int'(last_winner) + k) % NUM_CORES;
      if (req[cand]) begin
        win_any      = 1'b1;
        win_idx      = 3'(cand);
        win_oh       = '0;
        win_oh[cand] = 1'b1;
        win_addr     = req_addr[32*cand +: 32];
      end
    end
  end

  // Sequencer: grant, timed lookup, optional memory fetch and cache fill, then a one-cycle response.
  always_ff @(posedge clk2) begin
    if (reset) begin
      state       <= S_IDLE;
      last_winner <= 3'(NUM_CORES - 1);
      win_q       <= '0;
      lat_cnt     <= '0;
      grant       <= '0;
      resp_valid  <= 1'b0;
      resp_core   <= '0;
      resp_hit    <= 1'b0;
      c_reset     <= 1'b1;
      c_control   <= 1'b0;
      c_tag       <= '0;
      c_index     <= '0;
      c_offset    <= '0;
      c_block     <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      grant      <= '0;
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_any) begin
            state    <= S_GRANT;
            win_q    <= win_idx;
            grant    <= win_oh;
            c_tag    <= win_addr[31 -: TAG_W];
            c_index  <= win_addr[OFF_W +: IDX_W];
            c_offset <= win_addr[OFF_W-1:0];
          end
        end
        S_GRANT: begin
          // Pointer moves only once the grant is actually issued.
          last_winner <= win_q;
          lat_cnt     <= CNT_W'(1);
          c_reset     <= 1'b0;
          state       <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (lat_cnt == CNT_W'(LOOKUP_LAT)) begin
            if (c_found) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_hit   <= 1'b1;
              resp_core  <= win_q;
              c_reset    <= 1'b1;
              hit_cnt    <= (hit_cnt == 16'hFFFF) ? hit_cnt : hit_cnt + 16'd1;
            end else begin
              state    <= S_FETCH;
              mem_req  <= 1'b1;
              mem_addr <= {c_tag, c_index, {OFF_W{1'b0}}};
            end
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end
        S_FETCH: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            c_block   <= mem_block;
            c_control <= 1'b1;
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (c_updated) begin
            c_control  <= 1'b0;
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            resp_core  <= win_q;
            c_reset    <= 1'b1;
            miss_cnt   <= (miss_cnt == 16'hFFFF) ? miss_cnt : miss_cnt + 16'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_access_arbiter.sv
// Directed bench for cache_access_arbiter with a behavioural cache and memory model.
// Latency: checks exact grant/response cycles relative to request issue.
// Backpressure: memory answers MEM_WAIT cycles after mem_req; cache acks on the first fill cycle.
module tb_cache_access_arbiter;
  localparam int NC       = 4;
  localparam int MEM_WAIT = 3;

  logic          clk2 = 1'b0;
  logic          reset;
  logic [NC-1:0] req;
  logic [32*NC-1:0] req_addr;
  logic [NC-1:0] grant;
  logic          resp_valid;
  logic [2:0]    resp_core;
  logic          resp_hit;
  logic          c_reset;
  logic          c_control;
  logic [16:0]   c_tag;
  logic [10:0]   c_index;
  logic [3:0]    c_offset;
  logic [127:0]  c_block;
  logic          c_found;
  logic          c_updated = 1'b0;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ready;
  logic          mdl_ready = 1'b0;
  logic          stray_ready;
  logic [127:0]  mem_block;
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;

  bit            cv   [0:2047];
  bit [16:0]     ctag [0:2047];
  int            wait_cnt = 0;
  int            checks = 0;
  int            errors = 0;

  // captured per-transaction observations
  int            g_cyc, r_cyc, mreq_n;
  logic [NC-1:0] grant_s;
  logic [16:0]   tag_s;
  logic [10:0]   idx_s;
  logic [3:0]    off_s;
  logic          creset_g, creset_l, creset_r, hit_s, fill_seen, mreq_seen, addr_unstable;
  logic [2:0]    core_s;
  logic [15:0]   hc_s, mc_s;
  logic [31:0]   mreq_addr;
  logic [127:0]  fill_blk;

  always #5 clk2 = ~clk2;

  cache_access_arbiter dut (
    .clk2(clk2), .reset(reset), .req(req), .req_addr(req_addr), .grant(grant),
    .resp_valid(resp_valid), .resp_core(resp_core), .resp_hit(resp_hit),
    .c_reset(c_reset), .c_control(c_control), .c_tag(c_tag), .c_index(c_index),
    .c_offset(c_offset), .c_block(c_block), .c_found(c_found), .c_updated(c_updated),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_block(mem_block),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  assign c_found   = !c_reset && cv[c_index] && (ctag[c_index] == c_tag);
  assign mem_block = {mem_addr, ~mem_addr, mem_addr ^ 32'hA5A5A5A5, 32'h0BADF00D};
  assign mem_ready = mdl_ready | stray_ready;

  // cache acks a fill in the same cycle; memory answers MEM_WAIT cycles after mem_req rises
  always @(posedge clk2) begin
    #1;
    c_updated = c_control;
    if (c_control) begin
      cv[c_index]   = 1'b1;
      ctag[c_index] = c_tag;
    end
    if (mdl_ready) mdl_ready = 1'b0;
    else if (!mem_req) wait_cnt = 0;
    else if (wait_cnt == MEM_WAIT) begin
      mdl_ready = 1'b1;
      wait_cnt  = 0;
    end else wait_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // issue one request from a single core and record what happens until its response
  task automatic run_one(input int core, input logic [31:0] addr);
    @(negedge clk2);
    req[core] = 1'b1;
    req_addr[32*core +: 32] = addr;
    g_cyc = -1; r_cyc = -1; mreq_n = 0; grant_s = '0;
    creset_g = 1'bx; creset_l = 1'bx; creset_r = 1'bx;
    fill_seen = 1'b0; mreq_seen = 1'b0; addr_unstable = 1'b0;
    mreq_addr = '0; fill_blk = '0;
    for (int n = 1; n <= 60 && r_cyc < 0; n++) begin
      @(negedge clk2);
      if (grant != '0 && g_cyc < 0) begin
        g_cyc = n; grant_s = grant; tag_s = c_tag; idx_s = c_index; off_s = c_offset;
        creset_g = c_reset;
        req[core] = 1'b0;
      end
      if (g_cyc > 0 && n == g_cyc + 1) creset_l = c_reset;
      if (mem_req) begin
        mreq_n++;
        if (!mreq_seen) begin
          mreq_seen = 1'b1;
          mreq_addr = mem_addr;
        end else if (mem_addr !== mreq_addr) addr_unstable = 1'b1;
      end
      if (c_control && !fill_seen) begin
        fill_seen = 1'b1;
        fill_blk  = c_block;
      end
      if (resp_valid) begin
        r_cyc = n; hit_s = resp_hit; core_s = resp_core; creset_r = c_reset;
        hc_s = hit_count; mc_s = miss_count;
      end
    end
    req[core] = 1'b0;
  endtask

  initial begin
    logic [NC-1:0] seq [0:4];
    logic [NC-1:0] grant_or;
    int            ng, nresp;
    logic          found;
    logic [2:0]    rcore;

    reset = 1'b1; req = '0; req_addr = '0; stray_ready = 1'b0;
    repeat (3) @(negedge clk2);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_core", resp_core, 3'd0);
    chk("rst_resp_hit", resp_hit, 1'b0);
    chk("rst_c_reset", c_reset, 1'b1);
    chk("rst_c_control", c_control, 1'b0);
    chk("rst_c_addr", {c_tag, c_index, c_offset}, 32'h0);
    chk("rst_c_block", c_block, 128'h0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_hit_count", hit_count, 16'h0);
    chk("rst_miss_count", miss_count, 16'h0);
    reset = 1'b0;

    // stray mem_ready while idle must not disturb anything
    @(negedge clk2); stray_ready = 1'b1;
    @(negedge clk2); stray_ready = 1'b0;
    @(negedge clk2);
    chk("stray_mem_req", mem_req, 1'b0);
    chk("stray_c_control", c_control, 1'b0);
    chk("stray_c_block", c_block, 128'h0);

    // single hit: tag 0x00ABC, index 0x010, offset 4 -> addr 0x055E0104
    cv[16] = 1'b1; ctag[16] = 17'h00ABC;
    run_one(0, 32'h055E0104);
    chk("hit_grant_cyc", g_cyc, 1);
    chk("hit_grant", grant_s, 4'b0001);
    chk("hit_tag", tag_s, 17'h00ABC);
    chk("hit_index", idx_s, 11'h010);
    chk("hit_offset", off_s, 4'h4);
    chk("hit_creset_grant", creset_g, 1'b1);
    chk("hit_creset_lookup", creset_l, 1'b0);
    chk("hit_resp_cyc", r_cyc, 7);
    chk("hit_resp_hit", hit_s, 1'b1);
    chk("hit_resp_core", core_s, 3'd0);
    chk("hit_creset_resp", creset_r, 1'b1);
    chk("hit_count1", hc_s, 16'd1);
    chk("hit_miss_count", mc_s, 16'd0);
    @(negedge clk2);
    chk("hit_resp_pulse", resp_valid, 1'b0);

    // miss and fill: core 2, index 0x204 empty
    run_one(2, 32'h00002040);
    chk("miss_grant", grant_s, 4'b0100);
    chk("miss_mem_addr", mreq_addr, 32'h00002040);
    chk("miss_mem_addr_stable", addr_unstable, 1'b0);
    chk("miss_mem_req_cycles", mreq_n, 4);
    chk("miss_fill_seen", fill_seen, 1'b1);
    chk("miss_fill_block", fill_blk, {32'h00002040, 32'hFFFFDFBF, 32'hA5A585E5, 32'h0BADF00D});
    chk("miss_resp_cyc", r_cyc, 12);
    chk("miss_resp_hit", hit_s, 1'b0);
    chk("miss_resp_core", core_s, 3'd2);
    chk("miss_count1", mc_s, 16'd1);
    @(negedge clk2);
    chk("miss_c_control_drop", c_control, 1'b0);
    run_one(2, 32'h00002040);
    chk("refetch_resp_cyc", r_cyc, 7);
    chk("refetch_resp_hit", hit_s, 1'b1);
    chk("refetch_hit_count", hc_s, 16'd2);

    // reset during FETCH: core 3 misses on empty index 0x305
    @(negedge clk2);
    req[3] = 1'b1; req_addr[96 +: 32] = 32'h00003050;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk2);
      if (grant != '0) req[3] = 1'b0;
      if (mem_req) found = 1'b1;
    end
    chk("rstmid_reached_fetch", found, 1'b1);
    reset = 1'b1;
    @(negedge clk2);
    chk("rstmid_mem_req", mem_req, 1'b0);
    chk("rstmid_c_reset", c_reset, 1'b1);
    chk("rstmid_counts", {hit_count, miss_count}, 32'h0);
    reset = 1'b0;

    // round robin with all cores requesting continuously
    for (int i = 0; i < NC; i++) req_addr[32*i +: 32] = 32'h055E0104;
    req = 4'b1111;
    ng = 0;
    for (int n = 0; n < 100 && ng < 5; n++) begin
      @(negedge clk2);
      if (grant != '0) begin
        seq[ng] = grant;
        ng++;
        if (ng == 5) req = '0;
      end
    end
    req = '0;
    chk("rr_grant_count", ng, 5);
    chk("rr_g0", seq[0], 4'b0001);
    chk("rr_g1", seq[1], 4'b0010);
    chk("rr_g2", seq[2], 4'b0100);
    chk("rr_g3", seq[3], 4'b1000);
    chk("rr_g4", seq[4], 4'b0001);
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk2);
      if (resp_valid) found = 1'b1;
    end
    chk("rr_last_resp", found, 1'b1);
    chk("rr_hit_count", hit_count, 16'd5);

    // request withdrawn: core 1 pulses req while core 0 is being served
    @(negedge clk2);
    req[0] = 1'b1; req_addr[0 +: 32] = 32'h055E0104;
    grant_or = '0; nresp = 0; rcore = 3'd7;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk2);
      grant_or |= grant;
      if (n == 1) req[0] = 1'b0;
      if (n == 2) req[1] = 1'b1;
      if (n == 4) req[1] = 1'b0;
      if (resp_valid) begin
        nresp++;
        rcore = resp_core;
      end
    end
    chk("wd_grants", grant_or, 4'b0001);
    chk("wd_resp_count", nresp, 1);
    chk("wd_resp_core", rcore, 3'd0);

    // counter saturation
    @(negedge clk2);
    force dut.hit_cnt = 16'hFFFF;
    @(negedge clk2);
    release dut.hit_cnt;
    chk("sat_preset", hit_count, 16'hFFFF);
    run_one(0, 32'h055E0104);
    chk("sat_resp_hit", hit_s, 1'b1);
    chk("sat_hit_count", hc_s, 16'hFFFF);
    chk("sat_miss_count", mc_s, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
